// File: rtl/jtag_bitbang_master_if.sv
// Command/response channel of the JTAG bit-bang master.
// The requester drives cmd_* and receives rsp_*.
interface jtag_bitbang_master_if #(
    parameter int MAX_LEN = 32
);
    logic               cmd_valid;
    logic               cmd_ready;
    logic [1:0]         cmd_op;
    logic [5:0]         cmd_len;
    logic               cmd_last_tms;
    logic [MAX_LEN-1:0] cmd_data;
    logic               rsp_valid;
    logic [MAX_LEN-1:0] rsp_data;

    modport master (
        output cmd_valid, cmd_op, cmd_len, cmd_last_tms, cmd_data,
        input  cmd_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_len, cmd_last_tms, cmd_data,
        output cmd_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/jtag_bitbang_master.sv
// Word-level JTAG master: expands TAP_RESET / TMS_SEQ / SCAN / RUN_IDLE
// commands into TCK/TMS/TDI waveforms and captures TDO on rising TCK.
module jtag_bitbang_master #(
    parameter int TCK_DIV = 2,
    parameter int MAX_LEN = 32
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  enable,
    input  logic                  init_done,
    jtag_bitbang_master_if.slave  bus,
    output logic                  tck,
    output logic                  tms,
    output logic                  tdi,
    input  logic                  tdo
);
    localparam int IDXW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    typedef enum logic [1:0] {
        OP_TAP_RESET = 2'd0,
        OP_TMS_SEQ   = 2'd1,
        OP_SCAN      = 2'd2,
        OP_RUN_IDLE  = 2'd3
    } op_e;

    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_e;

    typedef struct packed {
        logic [1:0]         op;
        logic [5:0]         cnt;
        logic               last_tms;
        logic [MAX_LEN-1:0] data;
    } cmd_t;

    state_e             state;
    cmd_t               cur;
    logic [7:0]         div_cnt;
    logic [5:0]         bit_idx;
    logic [MAX_LEN-1:0] result;
    logic [MAX_LEN-1:0] result_nxt;
    logic [5:0]         eff_cnt;
    logic               rsp_valid_q;
    logic [MAX_LEN-1:0] rsp_data_q;
    logic               accept;
    logic               last_div;

    // TMS for bit idx of a command; TAP_RESET walks 1,1,1,1,1,0 into Run-Test/Idle.
    function automatic logic bit_tms(input logic [1:0] op, input logic [5:0] idx,
                                     input logic [5:0] cnt, input logic [MAX_LEN-1:0] data,
                                     input logic last);
        case (op)
            OP_TAP_RESET: bit_tms = (idx < 6'd5);
            OP_TMS_SEQ:   bit_tms = data[idx[IDXW-1:0]];
            OP_SCAN:      bit_tms = (idx == cnt - 6'd1) ? last : 1'b0;
            default:      bit_tms = 1'b0;
        endcase
    endfunction

    function automatic logic bit_tdi(input logic [1:0] op, input logic [5:0] idx,
                                     input logic [MAX_LEN-1:0] data);
        bit_tdi = (op == OP_SCAN) ? data[idx[IDXW-1:0]] : 1'b0;
    endfunction

    assign bus.cmd_ready = (state == IDLE) && enable && init_done;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign accept        = bus.cmd_valid && bus.cmd_ready;
    assign last_div      = (div_cnt == 8'(TCK_DIV - 1));

    always_comb begin
        eff_cnt = bus.cmd_len;
        if (bus.cmd_op == OP_TAP_RESET)
            eff_cnt = 6'd6;
        else if (bus.cmd_len > 6'(MAX_LEN))
            eff_cnt = 6'(MAX_LEN);
    end

    // With TCK_DIV=1 the sample cycle is also the last HIGH cycle, so the
    // freshly sampled bit must be visible when the response is loaded.
    always_comb begin
        result_nxt = result;
        if (state == HIGH && div_cnt == 8'd0)
            result_nxt[bit_idx[IDXW-1:0]] = tdo;
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            state       <= IDLE;
            cur         <= '0;
            div_cnt     <= '0;
            bit_idx     <= '0;
            result      <= '0;
            tck         <= 1'b0;
            tms         <= 1'b1;
            tdi         <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cur.op       <= bus.cmd_op;
                        cur.cnt      <= eff_cnt;
                        cur.last_tms <= bus.cmd_last_tms;
                        cur.data     <= bus.cmd_data;
                        result       <= '0;
                        bit_idx      <= '0;
                        div_cnt      <= '0;
                        if (eff_cnt == 6'd0) begin
                            state       <= DONE;
                            rsp_valid_q <= 1'b1;
                            rsp_data_q  <= '0;
                            tdi         <= 1'b0;
                        end else begin
                            state <= LOW;
                            tms   <= bit_tms(bus.cmd_op, 6'd0, eff_cnt, bus.cmd_data,
                                             bus.cmd_last_tms);
                            tdi   <= bit_tdi(bus.cmd_op, 6'd0, bus.cmd_data);
                        end
                    end
                end
                LOW: begin
                    if (last_div) begin
                        div_cnt <= '0;
                        tck     <= 1'b1;
                        state   <= HIGH;
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                HIGH: begin
                    result <= result_nxt;
                    if (last_div) begin
                        div_cnt <= '0;
                        tck     <= 1'b0;
                        if (bit_idx == cur.cnt - 6'd1) begin
                            state       <= DONE;
                            rsp_valid_q <= 1'b1;
                            rsp_data_q  <= (cur.op == OP_SCAN) ? result_nxt : '0;
                            tdi         <= 1'b0;
                        end else begin
                            bit_idx <= bit_idx + 6'd1;
                            state   <= LOW;
                            tms     <= bit_tms(cur.op, bit_idx + 6'd1, cur.cnt, cur.data,
                                               cur.last_tms);
                            tdi     <= bit_tdi(cur.op, bit_idx + 6'd1, cur.data);
                        end
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                DONE: begin
                    rsp_valid_q <= 1'b0;
                    rsp_data_q  <= '0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_jtag_bitbang_master.sv
// Randomized self-checking bench for jtag_bitbang_master against a
// per-command reference model of the expected TCK/TMS/TDI/TDO behaviour.
module tb_jtag_bitbang_master;
    localparam int D  = 2;
    localparam int ML = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enable = 1'b1;
    logic init_done = 1'b1;
    logic tck, tms, tdi;
    logic tdo = 1'b0;

    jtag_bitbang_master_if #(.MAX_LEN(ML)) bus ();

    jtag_bitbang_master #(.TCK_DIV(D), .MAX_LEN(ML)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst_n),
        .enable   (enable),
        .init_done(init_done),
        .bus      (bus),
        .tck      (tck),
        .tms      (tms),
        .tdi      (tdi),
        .tdo      (tdo)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Pin monitor: records TMS/TDI at each TCK rise, plays TDO back per bit.
    int          cyc = 0;
    int          pulses = 0;
    int          hi_len = 0;
    int          width_err = 0;
    int          rsp_cnt = 0;
    int          rsp_at = 0;
    logic [63:0] tms_seen = '0;
    logic [63:0] tdi_seen = '0;
    logic [63:0] tdo_vec = '0;
    logic [63:0] rsp_got = '0;
    logic        prev_tck = 1'b0;
    logic        model_tms = 1'b1;

    always @(negedge clk) begin
        cyc++;
        if (tck && !prev_tck) begin
            if (pulses < 64) begin
                tms_seen[pulses] = tms;
                tdi_seen[pulses] = tdi;
            end
            pulses++;
            hi_len = 0;
        end
        if (tck) hi_len++;
        if (!tck && prev_tck) begin
            if (hi_len != D) width_err++;
            tdo = (pulses < 64) ? tdo_vec[pulses] : 1'b0;
        end
        if (bus.rsp_valid) begin
            rsp_cnt++;
            rsp_at  = cyc;
            rsp_got = 64'(bus.rsp_data);
        end
        prev_tck = tck;
    end

    task automatic mon_clear(input logic [63:0] tv);
        pulses = 0; hi_len = 0; width_err = 0; rsp_cnt = 0; rsp_at = 0;
        tms_seen = '0; tdi_seen = '0; rsp_got = '0;
        tdo_vec = tv; tdo = tv[0];
    endtask

    task automatic run_cmd(input logic [1:0] op, input int len, input logic last,
                           input logic [31:0] data, input logic [63:0] tv,
                           input bit drop_en, input bit pre_blocked);
        int cnt, acc, waited, t, bad;
        logic [63:0] etms, etdi, ersp;
        logic idle_tms;
        cnt = (op == 2'd0) ? 6 : ((len > ML) ? ML : len);
        etms = '0; etdi = '0; ersp = '0;
        for (int i = 0; i < cnt; i++) begin
            case (op)
                2'd0: etms[i] = (i < 5);
                2'd1: etms[i] = data[i];
                2'd2: begin
                    etms[i] = (i == cnt - 1) ? last : 1'b0;
                    etdi[i] = data[i];
                    ersp[i] = tv[i];
                end
                default: ;
            endcase
        end
        idle_tms = (cnt > 0) ? etms[cnt-1] : model_tms;

        @(negedge clk); #1;
        mon_clear(tv);
        bus.cmd_op = op; bus.cmd_len = 6'(len); bus.cmd_last_tms = last; bus.cmd_data = data;
        if (pre_blocked) begin
            init_done = 1'b0;
            bus.cmd_valid = 1'b1;
            bad = 0;
            repeat (10) begin
                @(negedge clk); #1;
                if (bus.cmd_ready || tck) bad++;
            end
            chk("blocked_ready_tck", 64'(bad), 64'd0);
            chk("blocked_no_rsp", 64'(rsp_cnt), 64'd0);
            init_done = 1'b1;
            #1;
        end
        bus.cmd_valid = 1'b1;
        waited = 0;
        while (!bus.cmd_ready && waited < 100) begin
            @(negedge clk); #1;
            waited++;
        end
        chk("accept_wait", 64'(waited), 64'd0);
        acc = cyc;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        if (drop_en) enable = 1'b0;
        t = 0;
        while (rsp_cnt == 0 && t < 2000) begin
            @(negedge clk); #1;
            t++;
        end
        @(negedge clk); #1;
        chk("latency", 64'(rsp_at - acc), 64'(2 * cnt * D + 1));
        chk("rsp_count", 64'(rsp_cnt), 64'd1);
        chk("tck_pulses", 64'(pulses), 64'(cnt));
        chk("tms_bits", tms_seen, etms);
        chk("tdi_bits", tdi_seen, etdi);
        chk("rsp_data", rsp_got, ersp);
        chk("tck_high_width", 64'(width_err), 64'd0);
        chk("idle_tck", 64'(tck), 64'd0);
        chk("idle_tdi", 64'(tdi), 64'd0);
        chk("idle_tms", 64'(tms), 64'(idle_tms));
        chk("ready_after", 64'(bus.cmd_ready), 64'(!drop_en));
        enable = 1'b1;
        model_tms = idle_tms;
    endtask

    initial begin
        int t;
        bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_len = '0;
        bus.cmd_last_tms = 1'b0; bus.cmd_data = '0;

        repeat (3) @(negedge clk);
        #1;
        chk("rst_tck", 64'(tck), 64'd0);
        chk("rst_tms", 64'(tms), 64'd1);
        chk("rst_tdi", 64'(tdi), 64'd0);
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_rsp_data", 64'(bus.rsp_data), 64'd0);
        rst_n = 1'b1;
        @(negedge clk); #1;
        chk("rst_ready", 64'(bus.cmd_ready), 64'd1);

        // TAP reset ignores cmd_len; SCAN with looped-back TDO; all-ones TDO.
        run_cmd(2'd0, 13, 1'b0, $urandom, 64'd0, 1'b0, 1'b0);
        run_cmd(2'd2, 8, 1'b1, 32'hA5, 64'hA5, 1'b0, 1'b0);
        run_cmd(2'd2, 32, 1'b0, $urandom, '1, 1'b0, 1'b0);
        run_cmd(2'd2, 40, 1'b1, $urandom, {$urandom, $urandom}, 1'b0, 1'b0);
        run_cmd(2'd3, 5, 1'b0, $urandom, 64'd0, 1'b0, 1'b1);
        run_cmd(2'd1, 0, 1'b0, $urandom, 64'd0, 1'b0, 1'b0);
        run_cmd(2'd1, 7, 1'b0, 32'h55, 64'd0, 1'b1, 1'b0);

        // Reset during bit 3 of a SCAN aborts without a response.
        @(negedge clk); #1;
        mon_clear({$urandom, $urandom});
        bus.cmd_op = 2'd2; bus.cmd_len = 6'd8; bus.cmd_last_tms = 1'b1;
        bus.cmd_data = 32'hFF; bus.cmd_valid = 1'b1;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        t = 0;
        while (pulses < 4 && t < 200) begin
            @(negedge clk); #1;
            t++;
        end
        chk("abort_reached_bit3", 64'(pulses), 64'd4);
        rst_n = 1'b0;
        @(negedge clk); #1;
        chk("abort_tck", 64'(tck), 64'd0);
        chk("abort_tms", 64'(tms), 64'd1);
        chk("abort_tdi", 64'(tdi), 64'd0);
        chk("abort_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        #1;
        chk("abort_no_rsp", 64'(rsp_cnt), 64'd0);
        chk("abort_no_pulses", 64'(pulses), 64'd4);
        chk("abort_ready", 64'(bus.cmd_ready), 64'd1);
        model_tms = 1'b1;

        for (int k = 0; k < 40; k++) begin
            run_cmd(2'($urandom_range(0, 3)), $urandom_range(0, 40), 1'($urandom),
                    $urandom, {$urandom, $urandom}, ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 7) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
